// File: rtl/video_pkg.sv
// ---------------------------------------------------------------------------
// video_pkg
// Shared definitions for the HDMI read path: default pixel/line geometry and
// the state encoding used by the ping/pong line reader.
// ---------------------------------------------------------------------------
package video_pkg;

    localparam int VIDEO_DATA_WIDTH = 16;
    localparam int VIDEO_H_ACTIVE   = 1280;
    localparam int VIDEO_CNT_WIDTH  = 11;

    // Line reader states. The encoding is fixed so a debug port can be
    // compared against plain numbers.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,   // between lines, waiting for line_start
        ARMED  = 2'd1,   // line_start seen, waiting for first de_in
        ACTIVE = 2'd2,   // consuming one word per de_in cycle
        DRAIN  = 2'd3    // line cut short: discard the rest of the buffer
    } state_e;

endpackage : video_pkg

// File: rtl/line_pixel_counter.sv
// ---------------------------------------------------------------------------
// line_pixel_counter
// Pixel position within the current line. Wraps to zero after the last
// pixel so the next line starts at position 0 without a separate clear.
//
// Ports:
//   clk    in   clock
//   rst    in   asynchronous active-high reset
//   inc    in   advance one pixel position
//   clear  in   force position back to 0 (wins over inc)
//   cnt    out  current pixel position
//   last   out  cnt == H_ACTIVE-1
// ---------------------------------------------------------------------------
module line_pixel_counter #(
    parameter int H_ACTIVE  = 1280,
    parameter int CNT_WIDTH = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    input  logic                 clear,
    output logic [CNT_WIDTH-1:0] cnt,
    output logic                 last
);

    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(H_ACTIVE - 1);

    assign last = (cnt == LAST_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= last ? '0 : cnt + 1'b1;
        end
    end

endmodule : line_pixel_counter

// File: rtl/pingpong_line_reader.sv
// ---------------------------------------------------------------------------
// pingpong_line_reader
// Reads exactly one video line from each of two prefetch FIFOs in turn
// (ping, pong, ping, ...) paced by de_in, and presents a registered pixel
// stream. Missing words are replaced with FILL_DATA; a line that is cut
// short by an early line_start has its remaining words drained so the two
// buffers never fall out of line alignment.
//
// Ports:
//   rd_clk        in   pixel clock (FIFO read domain)
//   rd_rst        in   asynchronous active-high reset
//   frame_start   in   vsync pulse, realigns to ping
//   line_start    in   pulse before each active line
//   de_in         in   active-video request, one pixel per cycle
//   ping_rd_en    out  pop ping FIFO
//   ping_rd_vld   in   ping head word valid
//   ping_rd_data  in   ping head word
//   pong_rd_en    out  pop pong FIFO
//   pong_rd_vld   in   pong head word valid
//   pong_rd_data  in   pong head word
//   pix_de        out  de_in delayed one cycle
//   pix_data      out  registered pixel (FILL_DATA when pix_de=0)
//   line_sel      out  buffer being read, 0 = ping, 1 = pong
//   line_done     out  pulse after H_ACTIVE words consumed from a buffer
//   underflow     out  sticky: pixel requested with no word available
//   short_line    out  sticky: line_start arrived mid-line
//   dbg_state     out  current FSM state (video_pkg::state_e encoding)
//
// FIFO handshake: a word is consumed in a cycle where x_rd_en and
// x_rd_vld are both high. rd_en is derived from rd_vld, so it is never
// raised toward an empty FIFO, and only the selected FIFO is ever popped.
// ---------------------------------------------------------------------------
module pingpong_line_reader
    import video_pkg::*;
#(
    parameter int                    DATA_WIDTH = VIDEO_DATA_WIDTH,
    parameter int                    H_ACTIVE   = VIDEO_H_ACTIVE,
    parameter int                    CNT_WIDTH  = VIDEO_CNT_WIDTH,
    parameter logic [DATA_WIDTH-1:0] FILL_DATA  = '0
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic                  frame_start,
    input  logic                  line_start,
    input  logic                  de_in,
    output logic                  ping_rd_en,
    input  logic                  ping_rd_vld,
    input  logic [DATA_WIDTH-1:0] ping_rd_data,
    output logic                  pong_rd_en,
    input  logic                  pong_rd_vld,
    input  logic [DATA_WIDTH-1:0] pong_rd_data,
    output logic                  pix_de,
    output logic [DATA_WIDTH-1:0] pix_data,
    output logic                  line_sel,
    output logic                  line_done,
    output logic                  underflow,
    output logic                  short_line,
    output logic [1:0]            dbg_state
);

    state_e                  state;
    state_e                  state_nxt;
    logic                    pending;
    logic [CNT_WIDTH-1:0]    cnt;
    logic                    cnt_last;

    logic                    sel_vld;
    logic [DATA_WIDTH-1:0]   sel_data;
    logic                    pix_req;
    logic                    px_pop;
    logic                    drain_pop;
    logic                    pop;
    logic                    cnt_inc;
    logic                    line_end;

    assign sel_vld  = line_sel ? pong_rd_vld  : ping_rd_vld;
    assign sel_data = line_sel ? pong_rd_data : ping_rd_data;

    // ARMED's first de_in cycle is already a pixel of the line.
    assign pix_req   = de_in && ((state == ARMED) || (state == ACTIVE));
    assign px_pop    = pix_req && sel_vld;
    assign drain_pop = (state == DRAIN) && sel_vld;
    assign pop       = px_pop || drain_pop;

    // A requested pixel advances the position even when the FIFO was empty,
    // so later words still land on their own screen positions. While
    // draining only real pops count, because the goal is to empty the line.
    assign cnt_inc  = pix_req || drain_pop;
    assign line_end = cnt_inc && cnt_last;

    assign ping_rd_en = pop && !line_sel;
    assign pong_rd_en = pop &&  line_sel;
    assign dbg_state  = state;

    line_pixel_counter #(
        .H_ACTIVE  (H_ACTIVE),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_cnt (
        .clk   (rd_clk),
        .rst   (rd_rst),
        .inc   (cnt_inc),
        .clear (frame_start),
        .cnt   (cnt),
        .last  (cnt_last)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (line_start) state_nxt = ARMED;
            end
            ARMED: begin
                if (de_in) state_nxt = ACTIVE;
            end
            ACTIVE: begin
                if (line_end)        state_nxt = line_start ? ARMED : IDLE;
                else if (line_start) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (line_end) state_nxt = (pending || line_start) ? ARMED : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (frame_start) state_nxt = IDLE;
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state      <= IDLE;
            pending    <= 1'b0;
            line_sel   <= 1'b0;
            pix_de     <= 1'b0;
            pix_data   <= '0;
            line_done  <= 1'b0;
            underflow  <= 1'b0;
            short_line <= 1'b0;
        end else begin
            state    <= state_nxt;
            pix_de   <= de_in;
            pix_data <= px_pop ? sel_data : FILL_DATA;

            // Any requested pixel that did not get a real word is an underflow,
            // including requests outside ARMED/ACTIVE.
            if (de_in && !px_pop) underflow <= 1'b1;

            if (state == ACTIVE && line_start && !line_end) short_line <= 1'b1;

            if (frame_start) begin
                pending   <= 1'b0;
                line_sel  <= 1'b0;
                line_done <= 1'b0;
            end else begin
                line_done <= line_end;
                if (line_end) line_sel <= ~line_sel;
                if (state == DRAIN && line_end) begin
                    pending <= 1'b0;
                end else if ((state == ACTIVE && line_start && !line_end) ||
                             (state == DRAIN && line_start)) begin
                    pending <= 1'b1;
                end
            end
        end
    end

endmodule : pingpong_line_reader

// File: tb/tb_pingpong_line_reader.sv
// ---------------------------------------------------------------------------
// tb_pingpong_line_reader
// Directed bench with H_ACTIVE=8. Two small FIFO models feed the reader;
// every de_in pixel pushes its hand-computed value into exp_q and a monitor
// compares pix_data whenever pix_de is high.
// ---------------------------------------------------------------------------
module tb_pingpong_line_reader;

    localparam int          DW   = 16;
    localparam int          HA   = 8;
    localparam int          CW   = 4;
    localparam logic [15:0] FILL = 16'h0000;

    // ---------------- clock / reset ----------------
    logic rd_clk = 1'b0;
    logic rd_rst = 1'b1;
    always #5 rd_clk = ~rd_clk;

    logic          frame_start = 1'b0;
    logic          line_start  = 1'b0;
    logic          de_in       = 1'b0;
    logic          ping_rd_en, pong_rd_en;
    logic          ping_rd_vld, pong_rd_vld;
    logic [DW-1:0] ping_rd_data, pong_rd_data;
    logic          pix_de;
    logic [DW-1:0] pix_data;
    logic          line_sel, line_done, underflow, short_line;
    logic [1:0]    dbg_state;

    pingpong_line_reader #(
        .DATA_WIDTH (DW),
        .H_ACTIVE   (HA),
        .CNT_WIDTH  (CW),
        .FILL_DATA  (FILL)
    ) dut (
        .rd_clk       (rd_clk),
        .rd_rst       (rd_rst),
        .frame_start  (frame_start),
        .line_start   (line_start),
        .de_in        (de_in),
        .ping_rd_en   (ping_rd_en),
        .ping_rd_vld  (ping_rd_vld),
        .ping_rd_data (ping_rd_data),
        .pong_rd_en   (pong_rd_en),
        .pong_rd_vld  (pong_rd_vld),
        .pong_rd_data (pong_rd_data),
        .pix_de       (pix_de),
        .pix_data     (pix_data),
        .line_sel     (line_sel),
        .line_done    (line_done),
        .underflow    (underflow),
        .short_line   (short_line),
        .dbg_state    (dbg_state)
    );

    // ---------------- FIFO models ----------------
    logic [15:0] ping_mem [0:15];
    logic [15:0] pong_mem [0:15];
    int ping_wp = 0, ping_rp = 0, ping_pops = 0;
    int pong_wp = 0, pong_rp = 0, pong_pops = 0;

    assign ping_rd_vld  = (ping_wp != ping_rp);
    assign pong_rd_vld  = (pong_wp != pong_rp);
    assign ping_rd_data = ping_mem[ping_rp[3:0]];
    assign pong_rd_data = pong_mem[pong_rp[3:0]];

    always @(posedge rd_clk) begin
        if (ping_rd_en && ping_rd_vld) begin
            ping_rp   <= ping_rp + 1;
            ping_pops <= ping_pops + 1;
        end
        if (pong_rd_en && pong_rd_vld) begin
            pong_rp   <= pong_rp + 1;
            pong_pops <= pong_pops + 1;
        end
    end

    task automatic load_ping(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            ping_mem[ping_wp[3:0]] = 16'(first + i);
            ping_wp = ping_wp + 1;
        end
    endtask

    task automatic load_pong(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            pong_mem[pong_wp[3:0]] = 16'(first + i);
            pong_wp = pong_wp + 1;
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [DW-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Pixel monitor: one cycle after each de_in, compare against exp_q.
    initial begin
        forever begin
            @(posedge rd_clk);
            #1;
            if (pix_de) begin
                if (exp_q.size() == 0) chk("pix_unexpected", 32'(pix_data), 32'hFFFF_FFFF);
                else                   chk("pix_data", 32'(pix_data), 32'(exp_q.pop_front()));
            end else begin
                chk("pix_fill_idle", 32'(pix_data), 32'(FILL));
            end
        end
    end

    // Handshake monitor: mid-cycle, after inputs have settled.
    initial begin
        forever begin
            @(negedge rd_clk);
            #2;
            chk("ping_en_no_vld", 32'(ping_rd_en && !ping_rd_vld), 0);
            chk("pong_en_no_vld", 32'(pong_rd_en && !pong_rd_vld), 0);
            chk("unsel_en", 32'(line_sel ? ping_rd_en : pong_rd_en), 0);
        end
    end

    // ---------------- driver ----------------
    // One clock: drive at negedge, leave time for the posedge, then return
    // the pulses to 0. Checks after a call see that posedge's results.
    task automatic cycle(input logic ls, input logic de, input logic fs, input logic [15:0] exp);
        @(negedge rd_clk);
        line_start  = ls;
        de_in       = de;
        frame_start = fs;
        if (de) exp_q.push_back(exp);
        @(posedge rd_clk);
        #1;
        line_start  = 1'b0;
        de_in       = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic pixels(input int first, input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b0, 16'(first + i));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        repeat (3) @(negedge rd_clk);
        chk("rst_pix_de", 32'(pix_de), 0);
        chk("rst_pix_data", 32'(pix_data), 0);
        chk("rst_line_sel", 32'(line_sel), 0);
        chk("rst_line_done", 32'(line_done), 0);
        chk("rst_flags", 32'({underflow, short_line}), 0);
        chk("rst_rd_en", 32'({ping_rd_en, pong_rd_en}), 0);
        chk("rst_state", 32'(dbg_state), 0);
        @(negedge rd_clk);
        rd_rst = 1'b0;
        idle(2);

        // Two full lines: ping then pong.
        load_ping(16'h0001, 8);
        load_pong(16'h0101, 8);
        cycle(1'b1, 1'b0, 1'b0, 16'h0);
        chk("t1_armed", 32'(dbg_state), 1);
        pixels(16'h0001, 8);
        chk("t1_done", 32'(line_done), 1);
        chk("t1_sel_pong", 32'(line_sel), 1);
        chk("t1_idle", 32'(dbg_state), 0);
        idle(1);
        chk("t1_done_pulse", 32'(line_done), 0);
        cycle(1'b1, 1'b0, 1'b0, 16'h0);
        pixels(16'h0101, 8);
        chk("t1_done2", 32'(line_done), 1);
        chk("t1_sel_ping", 32'(line_sel), 0);
        chk("t1_flags", 32'({underflow, short_line}), 0);
        chk("t1_ping_pops", 32'(ping_pops), 8);
        chk("t1_pong_pops", 32'(pong_pops), 8);

        // Underflow: ping has 5 words for an 8-pixel line.
        load_ping(16'h0001, 5);
        cycle(1'b1, 1'b0, 1'b0, 16'h0);
        pixels(16'h0001, 5);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, FILL);
        chk("t2_done", 32'(line_done), 1);
        chk("t2_sel", 32'(line_sel), 1);
        chk("t2_underflow", 32'(underflow), 1);
        chk("t2_ping_pops", 32'(ping_pops), 13);
        load_pong(16'h0101, 8);
        cycle(1'b1, 1'b0, 1'b0, 16'h0);
        pixels(16'h0101, 8);
        chk("t2_sel_back", 32'(line_sel), 0);
        chk("t2_pong_pops", 32'(pong_pops), 16);

        // Short line: line_start after 4 pixels, remaining 4 words drained.
        load_ping(16'h0001, 8);
        load_pong(16'h0101, 8);
        cycle(1'b1, 1'b0, 1'b0, 16'h0);
        pixels(16'h0001, 4);
        chk("t3_short_pre", 32'(short_line), 0);
        cycle(1'b1, 1'b0, 1'b0, 16'h0);
        chk("t3_short", 32'(short_line), 1);
        chk("t3_drain", 32'(dbg_state), 3);
        idle(3);
        chk("t3_no_done_yet", 32'(line_done), 0);
        chk("t3_drain_pops", 32'(ping_pops), 20);
        idle(1);
        chk("t3_done", 32'(line_done), 1);
        chk("t3_sel", 32'(line_sel), 1);
        chk("t3_armed", 32'(dbg_state), 1);
        chk("t3_ping_pops", 32'(ping_pops), 21);
        pixels(16'h0101, 8);
        chk("t3_done2", 32'(line_done), 1);
        chk("t3_sel_back", 32'(line_sel), 0);

        // de_in gap of 3 cycles mid-line.
        load_ping(16'h0001, 8);
        cycle(1'b1, 1'b0, 1'b0, 16'h0);
        pixels(16'h0001, 3);
        idle(3);
        chk("t4_gap_pops", 32'(ping_pops), 24);
        chk("t4_gap_state", 32'(dbg_state), 2);
        chk("t4_gap_no_done", 32'(line_done), 0);
        pixels(16'h0004, 5);
        chk("t4_done", 32'(line_done), 1);
        chk("t4_sel", 32'(line_sel), 1);
        chk("t4_ping_pops", 32'(ping_pops), 29);

        // frame_start mid-line on pong.
        load_pong(16'h0101, 8);
        cycle(1'b1, 1'b0, 1'b0, 16'h0);
        pixels(16'h0101, 3);
        cycle(1'b0, 1'b0, 1'b1, 16'h0);
        chk("t5_sel", 32'(line_sel), 0);
        chk("t5_state", 32'(dbg_state), 0);
        chk("t5_no_done", 32'(line_done), 0);
        chk("t5_flags_kept", 32'({underflow, short_line}), 32'h3);
        idle(1);
        chk("t5_no_done2", 32'(line_done), 0);
        pong_wp = pong_rp;
        // A full ping line afterwards proves the position restarted at 0.
        load_ping(16'h0001, 8);
        cycle(1'b1, 1'b0, 1'b0, 16'h0);
        pixels(16'h0001, 7);
        chk("t5_not_early", 32'(line_done), 0);
        pixels(16'h0008, 1);
        chk("t5_done", 32'(line_done), 1);
        chk("t5_sel_pong", 32'(line_sel), 1);

        // Asynchronous reset mid-ACTIVE while de_in is high.
        load_pong(16'h0101, 8);
        cycle(1'b1, 1'b0, 1'b0, 16'h0);
        pixels(16'h0101, 3);
        @(negedge rd_clk);
        de_in = 1'b1;
        #1 rd_rst = 1'b1;
        #1;
        chk("t6_pix_de", 32'(pix_de), 0);
        chk("t6_pix_data", 32'(pix_data), 0);
        chk("t6_rd_en", 32'({ping_rd_en, pong_rd_en}), 0);
        chk("t6_sel", 32'(line_sel), 0);
        chk("t6_flags", 32'({underflow, short_line}), 0);
        chk("t6_state", 32'(dbg_state), 0);
        de_in = 1'b0;
        repeat (2) @(negedge rd_clk);
        rd_rst = 1'b0;
        idle(1);
        chk("t6_sel_after", 32'(line_sel), 0);
        chk("t6_state_after", 32'(dbg_state), 0);
        pong_wp = pong_rp;

        idle(2);
        chk("exp_q_empty", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_pingpong_line_reader

// File: doc/pingpong_line_reader.md
Name: pingpong_line_reader

Overview:
- Read-side consumer of the two 16-bit prefetch line FIFOs (ping and pong) in the HDMI path.
- Pulls exactly one video line per FIFO, alternating ping, pong, ping, and so on, paced by the display timing's active-video enable.
- Presents a registered pixel stream to the HDMI encoder. Underflow is filled with a constant; short lines are drained so line alignment is never lost.

Parameters:
- DATA_WIDTH, 16, pixel/FIFO word width.
- H_ACTIVE, 1280, pixels per active line; legal range 2..2047.
- CNT_WIDTH, 11, pixel counter width; must satisfy 2^CNT_WIDTH > H_ACTIVE.
- FILL_DATA, 16'h0000, pixel value emitted on underflow.

Ports:
- rd_clk  in  1  pixel clock; same domain as the FIFO read side.
- rd_rst  in  1  asynchronous, active-high reset.
- frame_start  in  1  1-cycle pulse at vsync; realigns to ping.
- line_start  in  1  1-cycle pulse before each active line.
- de_in  in  1  active-video request, one pixel per cycle while high.
- ping_rd_en  out  1  pop to ping FIFO.
- ping_rd_vld  in  1  ping head word valid.
- ping_rd_data  in  DATA_WIDTH  ping head word.
- pong_rd_en  out  1  pop to pong FIFO.
- pong_rd_vld  in  1  pong head word valid.
- pong_rd_data  in  DATA_WIDTH  pong head word.
- pix_de  out  1  registered de_in.
- pix_data  out  DATA_WIDTH  registered pixel.
- line_sel  out  1  buffer being read: 0 = ping, 1 = pong.
- line_done  out  1  1-cycle pulse when H_ACTIVE words have been consumed from the current buffer.
- underflow  out  1  sticky: de_in high with the selected FIFO empty.
- short_line  out  1  sticky: line_start arrived before H_ACTIVE pixels.

Behaviour:
- Reset (async, rd_rst=1):
  - state=IDLE, cnt=0, line_sel=0.
  - All outputs 0, including both rd_en, underflow and short_line.
- FIFO handshake: a word is consumed when x_rd_en && x_rd_vld in the same cycle. x_rd_en is never asserted while x_rd_vld=0. The non-selected FIFO's rd_en is always 0.
- IDLE:
  - line_start goes to ARMED.
  - de_in in IDLE produces FILL_DATA and sets underflow.
- ARMED: first cycle with de_in=1 goes to ACTIVE and is processed as an ACTIVE cycle.
- ACTIVE, each cycle with de_in=1:
  - rd_en = selected rd_vld (combinational).
  - Next pix_data = selected rd_data if rd_vld, else FILL_DATA, and underflow is set.
  - cnt increments whether or not the pop succeeded, so the pixel position is preserved.
  - With de_in=0: no pop, cnt holds.
- End of line: the cycle where cnt==H_ACTIVE-1 is counted:
  - cnt returns to 0, line_done=1 next cycle, line_sel toggles, state goes to IDLE.
- Underflowed positions leave unread words in the FIFO; those are not skipped.
- line_start in ACTIVE with cnt<H_ACTIVE:
  - Set short_line and go to DRAIN.
  - Record a pending line_start.
- DRAIN:
  - Pops the selected FIFO whenever rd_vld=1, regardless of de_in, until cnt reaches H_ACTIVE-1.
  - Then line_done, toggle line_sel, and go to ARMED if pending, else IDLE.
  - de_in during DRAIN outputs FILL_DATA and sets underflow.
- frame_start (priority over line_start):
  - Next cycle: state=IDLE, cnt=0, line_sel=0, pending cleared, no line_done.
  - Sticky flags are kept.
- Latency: pix_de/pix_data are exactly 1 cycle after de_in. pix_data=FILL_DATA when pix_de=0.
- Sticky flags clear only on rd_rst.

Decomposition:
- Shared package (video_pkg):
  - state enum {IDLE, ARMED, ACTIVE, DRAIN}.
  - DATA_WIDTH default 16, H_ACTIVE default 1280.
- One natural sub-module, line_pixel_counter:
  - Inputs: inc, clear. Outputs: cnt, last (cnt==H_ACTIVE-1).
  - Async active-high reset.
- FSM, pixel mux and flags stay in the top module.

Test Plan (H_ACTIVE=8):
- Ping preloaded 0x0001..0x0008, pong 0x0101..0x0108; line_start then 8 de_in cycles. Expect:
  - pix_data 0x0001..0x0008 one cycle after de_in.
  - line_done on the cycle after the last pixel; line_sel goes to 1.
  - Second line outputs 0x0101..0x0108; line_sel returns to 0.
- Ping holds only 5 words during an 8-pixel de_in burst. Expect 0x0001..0x0005, then FILL_DATA x3, underflow=1, line_done still after the 8th cycle.
- line_start after 4 pixels with ping holding 8 words. Expect:
  - short_line=1; 4 more ping pops occur with de_in=0.
  - line_done, line_sel=1, state ARMED.
  - The next de_in burst reads pong 0x0101..0x0108.
- de_in deasserted for 3 cycles mid-line. Expect no pops and cnt holding; the line completes after 8 total de_in cycles with correct data order.
- frame_start issued while line_sel=1 mid-line. Expect line_sel=0, cnt=0, state IDLE, no line_done pulse, underflow/short_line unchanged.
- rd_rst asserted mid-ACTIVE. Expect all outputs 0 immediately (asynchronous), rd_en=0, and line_sel=0 after release.
